// File: rtl/meas_accum_mc.sv
// meas_accum_mc - multi-channel integrate-and-dump with per-channel result FIFOs.
//
// Each channel integrates N_SAMP parallel I/Q samples per clock over a window
// of programmable length, saturating at the accumulator limits. The window then
// dumps: the I sum is compared against a signed threshold and
// {acc_i, acc_q, bit} is queued in a first-word fall-through FIFO that the
// consumer drains with valid/ready.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   samp_i, samp_q        packed samples, ch c / sample s at [(c*N_SAMP+s)*SAMP_WIDTH +: SAMP_WIDTH]
//   start                 per-channel window start strobe
//   win_len, thresh       per-channel window length (0 treated as 1) and I threshold, taken with start
//   res_ready/res_valid   per-channel FIFO handshake
//   res_acc_i/q, res_bit  FIFO head (driven to 0 while the FIFO is empty)
//   busy                  channel is integrating or dumping
//   clr_err               clears the sticky error flags
//   err_coll, err_ovf     sticky: start while busy / result dropped on full FIFO
module meas_accum_mc #(
  parameter int N_CHAN     = 4,
  parameter int N_SAMP     = 4,
  parameter int SAMP_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int WIN_WIDTH  = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [N_CHAN*N_SAMP*SAMP_WIDTH-1:0]  samp_i,
  input  logic [N_CHAN*N_SAMP*SAMP_WIDTH-1:0]  samp_q,
  input  logic [N_CHAN-1:0]                    start,
  input  logic [N_CHAN*WIN_WIDTH-1:0]          win_len,
  input  logic [N_CHAN*ACC_WIDTH-1:0]          thresh,
  input  logic [N_CHAN-1:0]                    res_ready,
  output logic [N_CHAN-1:0]                    res_valid,
  output logic [N_CHAN*ACC_WIDTH-1:0]          res_acc_i,
  output logic [N_CHAN*ACC_WIDTH-1:0]          res_acc_q,
  output logic [N_CHAN-1:0]                    res_bit,
  output logic [N_CHAN-1:0]                    busy,
  input  logic                                 clr_err,
  output logic [N_CHAN-1:0]                    err_coll,
  output logic [N_CHAN-1:0]                    err_ovf
);

  localparam int SUM_W = SAMP_WIDTH + $clog2(N_SAMP);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ACCUM, DUMP} state_t;

  // Add a sign-extended per-clock sum to the accumulator, clamping on overflow.
  function automatic logic signed [ACC_WIDTH-1:0] sat_add(
    input logic signed [ACC_WIDTH-1:0] a,
    input logic signed [SUM_W-1:0]     b
  );
    logic [ACC_WIDTH:0] s;
    s = {a[ACC_WIDTH-1], a} + {{(ACC_WIDTH+1-SUM_W){b[SUM_W-1]}}, b};
    if (s[ACC_WIDTH] != s[ACC_WIDTH-1])
      sat_add = s[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                             : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    else
      sat_add = s[ACC_WIDTH-1:0];
  endfunction

  for (genvar c = 0; c < N_CHAN; c++) begin : g_chan
    state_t                       state, state_nxt;
    logic [WIN_WIDTH-1:0]         cnt;
    logic [WIN_WIDTH-1:0]         len_c;
    logic signed [ACC_WIDTH-1:0]  thr;
    logic signed [SUM_W-1:0]      sum_i_c, sum_q_c;
    logic signed [SUM_W-1:0]      sum_i_p1, sum_q_p1;
    logic signed [ACC_WIDTH-1:0]  acc_i_p2, acc_q_p2;
    logic [PTR_W:0]               wr_ptr, rd_ptr;
    logic signed [ACC_WIDTH-1:0]  mem_i [FIFO_DEPTH];
    logic signed [ACC_WIDTH-1:0]  mem_q [FIFO_DEPTH];
    logic                         mem_b [FIFO_DEPTH];
    logic                         launch, coll, push, pop, empty, full, wr_en, drop;
    logic                         dump_bit;
    logic                         coll_flag, ovf_flag;

    always_comb begin
      sum_i_c = '0;
      sum_q_c = '0;
      for (int s = 0; s < N_SAMP; s++) begin
        sum_i_c = sum_i_c + SUM_W'($signed(samp_i[(c*N_SAMP+s)*SAMP_WIDTH +: SAMP_WIDTH]));
        sum_q_c = sum_q_c + SUM_W'($signed(samp_q[(c*N_SAMP+s)*SAMP_WIDTH +: SAMP_WIDTH]));
      end
    end

    assign len_c  = (win_len[c*WIN_WIDTH +: WIN_WIDTH] == '0) ? WIN_WIDTH'(1)
                                                              : win_len[c*WIN_WIDTH +: WIN_WIDTH];
    assign launch = start[c] && (state == IDLE);
    assign coll   = start[c] && (state != IDLE);

    // ---- stage p1: per-clock sum of the N_SAMP lanes ----
    always_ff @(posedge clk) begin
      sum_i_p1 <= sum_i_c;
      sum_q_p1 <= sum_q_c;
    end

    // The window opens on the start cycle; the FSM enters ACCUM one clock
    // later, exactly when that cycle's sum appears at the p1 register, so the
    // len ACCUM cycles consume the len captured sums.
    always_comb begin
      state_nxt = state;
      case (state)
        IDLE:    if (start[c]) state_nxt = ACCUM;
        ACCUM:   if (cnt == WIN_WIDTH'(1)) state_nxt = DUMP;
        DUMP:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        state <= state_nxt;
        if (launch)
          cnt <= len_c;
        else if (state == ACCUM)
          cnt <= cnt - WIN_WIDTH'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (launch)
        thr <= $signed(thresh[c*ACC_WIDTH +: ACC_WIDTH]);
    end

    // ---- stage p2: saturating accumulation, cleared on dump ----
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        acc_i_p2 <= '0;
        acc_q_p2 <= '0;
      end else if (state == ACCUM) begin
        acc_i_p2 <= sat_add(acc_i_p2, sum_i_p1);
        acc_q_p2 <= sat_add(acc_q_p2, sum_q_p1);
      end else if (state == DUMP) begin
        acc_i_p2 <= '0;
        acc_q_p2 <= '0;
      end
    end

    assign dump_bit = (acc_i_p2 >= thr);

    // ---- result FIFO: extra pointer bit distinguishes full from empty ----
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign push  = (state == DUMP);
    assign pop   = !empty && res_ready[c];
    // A pop frees the slot in the same cycle, so a full FIFO still accepts.
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        coll_flag <= 1'b0;
        ovf_flag  <= 1'b0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + 1'b1;
        if (pop)   rd_ptr <= rd_ptr + 1'b1;
        coll_flag <= coll || (coll_flag && !clr_err);
        ovf_flag  <= drop || (ovf_flag && !clr_err);
      end
    end

    always_ff @(posedge clk) begin
      if (wr_en) begin
        mem_i[wr_ptr[PTR_W-1:0]] <= acc_i_p2;
        mem_q[wr_ptr[PTR_W-1:0]] <= acc_q_p2;
        mem_b[wr_ptr[PTR_W-1:0]] <= dump_bit;
      end
    end

    assign res_valid[c]                         = !empty;
    assign res_acc_i[c*ACC_WIDTH +: ACC_WIDTH]  = empty ? '0 : mem_i[rd_ptr[PTR_W-1:0]];
    assign res_acc_q[c*ACC_WIDTH +: ACC_WIDTH]  = empty ? '0 : mem_q[rd_ptr[PTR_W-1:0]];
    assign res_bit[c]                           = !empty && mem_b[rd_ptr[PTR_W-1:0]];
    assign busy[c]                              = (state != IDLE);
    assign err_coll[c]                          = coll_flag;
    assign err_ovf[c]                           = ovf_flag;
  end

endmodule

// File: tb/tb_meas_accum_mc.sv
// Testbench for meas_accum_mc: table of single-window vectors plus directed
// sequences for saturation, FIFO overflow, collisions, staggered channels and
// mid-window reset.
module tb_meas_accum_mc;
  localparam int N   = 4;
  localparam int S   = 4;
  localparam int SW  = 16;
  localparam int AW  = 40;
  localparam int WW  = 16;
  localparam int FD  = 8;
  localparam int AWB = 20;
  localparam int JUNK = 257;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [N*S*SW-1:0] samp_i, samp_q;
  logic [N-1:0]      start, res_ready;
  logic [N*WW-1:0]   win_len;
  logic [N*AW-1:0]   thresh;
  logic              clr_err;
  logic [N-1:0]      res_valid, res_bit, busy, err_coll, err_ovf;
  logic [N*AW-1:0]   res_acc_i, res_acc_q;

  logic [N*S*SW-1:0] b_samp_i, b_samp_q;
  logic [N-1:0]      b_start;
  logic [N*WW-1:0]   b_win_len;
  logic [N*AWB-1:0]  b_thresh;
  logic [N-1:0]      b_res_valid, b_res_bit, b_busy, b_err_coll, b_err_ovf;
  logic [N*AWB-1:0]  b_res_acc_i, b_res_acc_q;

  int checks = 0;
  int errors = 0;

  meas_accum_mc #(.N_CHAN(N), .N_SAMP(S), .SAMP_WIDTH(SW), .ACC_WIDTH(AW),
                  .WIN_WIDTH(WW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset_n(reset_n), .samp_i(samp_i), .samp_q(samp_q),
    .start(start), .win_len(win_len), .thresh(thresh), .res_ready(res_ready),
    .res_valid(res_valid), .res_acc_i(res_acc_i), .res_acc_q(res_acc_q),
    .res_bit(res_bit), .busy(busy), .clr_err(clr_err),
    .err_coll(err_coll), .err_ovf(err_ovf));

  meas_accum_mc #(.N_CHAN(N), .N_SAMP(S), .SAMP_WIDTH(SW), .ACC_WIDTH(AWB),
                  .WIN_WIDTH(WW), .FIFO_DEPTH(FD)) dut_b (
    .clk(clk), .reset_n(reset_n), .samp_i(b_samp_i), .samp_q(b_samp_q),
    .start(b_start), .win_len(b_win_len), .thresh(b_thresh), .res_ready(res_ready),
    .res_valid(b_res_valid), .res_acc_i(b_res_acc_i), .res_acc_q(b_res_acc_q),
    .res_bit(b_res_bit), .busy(b_busy), .clr_err(clr_err),
    .err_coll(b_err_coll), .err_ovf(b_err_ovf));

  always #5 clk = ~clk;

  typedef struct {
    int     ch;
    int     len;
    int     vi;
    int     vq;
    longint th;
    longint ei;
    longint eq;
    int     eb;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input int vi, input int vq);
    for (int s = 0; s < S; s++) begin
      samp_i[(ch*S+s)*SW +: SW] = 16'(vi);
      samp_q[(ch*S+s)*SW +: SW] = 16'(vq);
    end
  endtask

  function automatic longint head_i(input int ch);
    return longint'($signed(res_acc_i[ch*AW +: AW]));
  endfunction

  function automatic longint head_q(input int ch);
    return longint'($signed(res_acc_q[ch*AW +: AW]));
  endfunction

  task automatic pop(input int ch);
    res_ready[ch] = 1'b1;
    step();
    res_ready[ch] = 1'b0;
  endtask

  task automatic wait_idle(input int ch);
    int n;
    n = 0;
    while (busy[ch] && n < 200) begin
      step();
      n++;
    end
    chk("wait_idle_timeout", longint'(busy[ch]), 0);
  endtask

  // Runs one window with constant samples and junk outside it; lat counts
  // clock edges from the last integrated sample until the channel goes idle.
  task automatic drive_window(input int ch, input int len, input int vi, input int vq,
                              input longint th, output int lat, output bit early);
    int n;
    n = (len < 1) ? 1 : len;
    start[ch] = 1'b1;
    win_len[ch*WW +: WW] = 16'(len);
    thresh[ch*AW +: AW] = AW'(th);
    set_ch(ch, vi, vq);
    for (int k = 0; k < n; k++) begin
      step();
      start[ch] = 1'b0;
    end
    set_ch(ch, JUNK, JUNK);
    lat = 1;
    early = 1'b0;
    while (busy[ch] && lat < 100) begin
      if (res_valid[ch]) early = 1'b1;
      step();
      lat++;
    end
  endtask

  initial begin
    int  lat;
    bit  early;
    int  vals[4];
    int  lens[4];
    int  exp_list[8];

    vecs[0] = '{0, 10,  100,    -50,     3999,     4000,    -2000, 1};
    vecs[1] = '{0,  0,    7,      3,       28,       28,       12, 1};
    vecs[2] = '{1,  1,    7,      3,       29,       28,       12, 0};
    vecs[3] = '{2,  3, -200,     50,    -2400,    -2400,      600, 1};
    vecs[4] = '{3,  5,   -1,      1,        0,      -20,       20, 0};
    vecs[5] = '{1, 16, 32767, -32768, 2097089,  2097088, -2097152, 0};
    vecs[6] = '{2,  2,    0,      0,        0,        0,        0, 1};

    start = '0; res_ready = '0; win_len = '0; thresh = '0; clr_err = 1'b0;
    b_start = '0; b_win_len = '0; b_thresh = '0;
    for (int c = 0; c < N; c++) set_ch(c, JUNK, JUNK);
    b_samp_i = '0; b_samp_q = '0;

    // Reset state
    step(); step();
    chk("rst_busy", longint'(busy), 0);
    chk("rst_valid", longint'(res_valid), 0);
    chk("rst_acc_i", longint'(res_acc_i != '0), 0);
    chk("rst_acc_q", longint'(res_acc_q != '0), 0);
    chk("rst_bit", longint'(res_bit), 0);
    chk("rst_err", longint'({err_coll, err_ovf}), 0);
    reset_n = 1'b1;
    step();

    // Table-driven single windows
    for (int i = 0; i < 7; i++) begin
      drive_window(vecs[i].ch, vecs[i].len, vecs[i].vi, vecs[i].vq, vecs[i].th, lat, early);
      chk($sformatf("v%0d_latency", i), lat, 3);
      chk($sformatf("v%0d_early_valid", i), longint'(early), 0);
      chk($sformatf("v%0d_valid", i), longint'(res_valid[vecs[i].ch]), 1);
      chk($sformatf("v%0d_acc_i", i), head_i(vecs[i].ch), vecs[i].ei);
      chk($sformatf("v%0d_acc_q", i), head_q(vecs[i].ch), vecs[i].eq);
      chk($sformatf("v%0d_bit", i), longint'(res_bit[vecs[i].ch]), vecs[i].eb);
      pop(vecs[i].ch);
      chk($sformatf("v%0d_valid_after_pop", i), longint'(res_valid[vecs[i].ch]), 0);
    end
    chk("table_err_coll", longint'(err_coll), 0);
    chk("table_err_ovf", longint'(err_ovf), 0);

    // Saturation on the narrow accumulator instance
    for (int k = 0; k < N*S; k++) begin
      b_samp_i[k*SW +: SW] = 16'h7fff;
      b_samp_q[k*SW +: SW] = 16'h8000;
    end
    b_start[0] = 1'b1;
    b_win_len[0 +: WW] = 16'd100;
    step();
    b_start[0] = 1'b0;
    for (int n = 0; n < 300 && !b_res_valid[0]; n++) step();
    chk("sat_valid", longint'(b_res_valid[0]), 1);
    chk("sat_pos_i", longint'($signed(b_res_acc_i[0 +: AWB])), 524287);
    chk("sat_neg_q", longint'($signed(b_res_acc_q[0 +: AWB])), -524288);
    chk("sat_bit", longint'(b_res_bit[0]), 1);

    // FIFO overflow, clear, push+pop while full, ordered drain
    for (int k = 0; k < 8; k++) drive_window(0, 2, k+1, -(k+1), 0, lat, early);
    chk("fifo8_ovf", longint'(err_ovf), 0);
    chk("fifo8_valid", longint'(res_valid[0]), 1);
    drive_window(0, 2, 9, -9, 0, lat, early);
    chk("fifo9_ovf", longint'(err_ovf), 1);
    chk("fifo9_head", head_i(0), 8);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("ovf_cleared", longint'(err_ovf), 0);
    start[0] = 1'b1;
    win_len[0 +: WW] = 16'd2;
    set_ch(0, 10, -10);
    step();
    start[0] = 1'b0;
    step();
    set_ch(0, JUNK, JUNK);
    step();
    chk("full_dump_busy", longint'(busy[0]), 1);
    res_ready[0] = 1'b1;
    step();
    res_ready[0] = 1'b0;
    chk("pushpop_no_ovf", longint'(err_ovf), 0);
    exp_list = '{2, 3, 4, 5, 6, 7, 8, 10};
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("drain%0d_valid", k), longint'(res_valid[0]), 1);
      chk($sformatf("drain%0d_i", k), head_i(0), 8*exp_list[k]);
      chk($sformatf("drain%0d_q", k), head_q(0), -8*exp_list[k]);
      pop(0);
    end
    chk("drain_empty", longint'(res_valid[0]), 0);

    // Collision during ACCUM: window not restarted
    set_ch(1, 10, 0);
    start[1] = 1'b1;
    win_len[1*WW +: WW] = 16'd8;
    step();
    start[1] = 1'b0;
    step(); step();
    start[1] = 1'b1;
    win_len[1*WW +: WW] = 16'd20;
    step();
    start[1] = 1'b0;
    chk("coll_flag", longint'(err_coll), 2);
    wait_idle(1);
    chk("coll_acc_i", head_i(1), 320);
    pop(1);
    set_ch(1, JUNK, JUNK);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("coll_cleared", longint'(err_coll), 0);

    // Start during DUMP is a collision and is ignored
    set_ch(1, 5, 1);
    start[1] = 1'b1;
    win_len[1*WW +: WW] = 16'd2;
    step();
    start[1] = 1'b0;
    step();
    set_ch(1, JUNK, JUNK);
    step();
    chk("dump_busy", longint'(busy[1]), 1);
    start[1] = 1'b1;
    win_len[1*WW +: WW] = 16'd4;
    step();
    start[1] = 1'b0;
    chk("dump_coll", longint'(err_coll[1]), 1);
    chk("dump_start_ignored", longint'(busy[1]), 0);
    chk("dump_acc_i", head_i(1), 40);
    pop(1);

    // clr_err with a same-cycle new error: new error wins
    set_ch(2, 1, 1);
    start[2] = 1'b1;
    win_len[2*WW +: WW] = 16'd6;
    step();
    start[2] = 1'b0;
    clr_err = 1'b1;
    start[2] = 1'b1;
    step();
    clr_err = 1'b0;
    start[2] = 1'b0;
    chk("clr_vs_new_err", longint'(err_coll), 4);
    wait_idle(2);
    pop(2);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;

    // Staggered independent channels
    vals = '{11, -13, 17, -19};
    lens = '{3, 5, 7, 4};
    thresh = '0;
    for (int c = 0; c < N; c++) set_ch(c, vals[c], -vals[c]);
    for (int c = 0; c < N; c++) begin
      start = '0;
      start[c] = 1'b1;
      win_len[c*WW +: WW] = 16'(lens[c]);
      step();
    end
    start = '0;
    for (int n = 0; n < 200 && busy != '0; n++) step();
    chk("stagger_idle", longint'(busy), 0);
    chk("stagger_no_coll", longint'(err_coll), 0);
    for (int c = 0; c < N; c++) begin
      chk($sformatf("stagger%0d_i", c), head_i(c), 4*vals[c]*lens[c]);
      chk($sformatf("stagger%0d_q", c), head_q(c), -4*vals[c]*lens[c]);
      chk($sformatf("stagger%0d_bit", c), longint'(res_bit[c]), (vals[c] >= 0) ? 1 : 0);
    end
    pop(0);
    pop(1);
    for (int c = 0; c < N; c++) set_ch(c, JUNK, JUNK);

    // Reset mid-window with held results and a pending error flag
    set_ch(0, 50, 50);
    start[0] = 1'b1;
    win_len[0 +: WW] = 16'd20;
    step();
    start[0] = 1'b0;
    step(); step();
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    step();
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", longint'(busy), 0);
    chk("midrst_valid", longint'(res_valid), 0);
    chk("midrst_acc", longint'((res_acc_i != '0) || (res_acc_q != '0)), 0);
    chk("midrst_bit", longint'(res_bit), 0);
    chk("midrst_err", longint'({err_coll, err_ovf}), 0);
    step(); step();
    reset_n = 1'b1;
    set_ch(0, JUNK, JUNK);
    step();
    chk("postrst_valid", longint'(res_valid), 0);
    drive_window(0, 5, 3, -3, 0, lat, early);
    chk("postrst_latency", lat, 3);
    chk("postrst_acc_i", head_i(0), 60);
    chk("postrst_acc_q", head_q(0), -60);
    chk("postrst_err", longint'({err_coll, err_ovf}), 0);
    pop(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
